// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for a pipeline MEM stage: IDLE/WAIT/RESP handshake over a word array with byte/half/word access.
// Optional build macro DMEM_RESP_ALIGN_CHECK_EN reports misaligned accesses instead of silently aligning them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemR,
    input  logic        MemWr,
    input  logic [2:0]  MemRBits,
    input  logic [1:0]  MemWrBits,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        resp_valid,
    output logic [31:0] ReadData,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [2:0]    rbits_q, rbits_d;
    logic [1:0]    wbits_q, wbits_d;
    logic          is_wr_q, is_wr_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          idle;
    logic          accept;
    logic          enter_resp;
    logic          mem_we;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_data;
    logic [2:0]    cur_rbits;
    logic [1:0]    cur_wbits;
    logic          cur_wr;
    logic [AW-1:0] cur_idx;
    logic [1:0]    cur_off;
    logic [1:0]    eff_off;
    logic          is_word;
    logic          is_half;
    logic          is_signed;
    logic          misaligned;
    logic          access_err;
    logic [31:0]   old_word;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [31:0]   load_val;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   merged_word;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^addr[31:AW+2];

    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && req_valid && (MemR || MemWr);

    // In IDLE the live inputs are decoded so a zero-wait access can respond on its accept edge.
    assign cur_addr  = idle ? addr[AW+1:0] : addr_q;
    assign cur_data  = idle ? data         : data_q;
    assign cur_rbits = idle ? MemRBits     : rbits_q;
    assign cur_wbits = idle ? MemWrBits    : wbits_q;
    assign cur_wr    = idle ? MemWr        : is_wr_q;
    assign cur_idx   = cur_addr[AW+1:2];
    assign cur_off   = cur_addr[1:0];

    always_comb begin
        is_word   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        if (cur_wr) begin
            case (cur_wbits)
                2'b01:   is_half = 1'b1;
                2'b10:   is_word = 1'b0;
                default: is_word = 1'b1;
            endcase
        end else begin
            case (cur_rbits)
                3'b001: begin
                    is_half   = 1'b1;
                    is_signed = 1'b1;
                end
                3'b010:  is_half   = 1'b1;
                3'b011:  is_signed = 1'b1;
                3'b100:  is_word   = 1'b0;
                default: is_word   = 1'b1;
            endcase
        end
    end

    assign misaligned = (is_word && (cur_off != 2'b00)) || (is_half && cur_off[0]);

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    assign eff_off    = cur_off;
    assign access_err = misaligned;
`else
    assign eff_off    = is_word ? 2'b00 : (is_half ? {cur_off[1], 1'b0} : cur_off);
    assign access_err = 1'b0;
`endif

    assign old_word = mem[cur_idx];
    assign byte_val = old_word[{eff_off, 3'b000} +: 8];
    assign half_val = eff_off[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        if (is_word) begin
            load_val = old_word;
        end else if (is_half) begin
            load_val = {{16{is_signed & half_val[15]}}, half_val};
        end else begin
            load_val = {{24{is_signed & byte_val[7]}}, byte_val};
        end
    end

    always_comb begin
        if (is_word) begin
            byte_en  = 4'b1111;
            wr_lanes = cur_data;
        end else if (is_half) begin
            byte_en  = eff_off[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{cur_data[15:0]}};
        end else begin
            byte_en  = 4'b0001 << eff_off;
            wr_lanes = {4{cur_data[7:0]}};
        end
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[i*8 +: 8] = wr_lanes[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rbits_d = rbits_q;
        wbits_d = wbits_q;
        is_wr_d = is_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = addr[AW+1:0];
                    data_d  = data;
                    rbits_d = MemRBits;
                    wbits_d = MemWrBits;
                    is_wr_d = MemWr;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // Outputs are registered against the next state so they line up with the RESP cycle.
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = enter_resp;
        resp_err_d   = enter_resp && access_err;
        rdata_d      = 32'd0;
        if (enter_resp && !cur_wr && !access_err) begin
            rdata_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            data_q       <= 32'd0;
            rbits_q      <= 3'd0;
            wbits_q      <= 2'd0;
            is_wr_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rbits_q      <= rbits_d;
            wbits_q      <= wbits_d;
            is_wr_q      <= is_wr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    // The store commits on the edge that closes RESP; a reset before then drops it.
    assign mem_we = (state_q == ST_RESP) && is_wr_q && !access_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= merged_word;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign ReadData   = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array reference model.
// Expectations follow DMEM_RESP_ALIGN_CHECK_EN the same way the design does.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WAITC = 2;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemR = 1'b0;
    logic        MemWr = 1'b0;
    logic [2:0]  MemRBits = 3'd0;
    logic [1:0]  MemWrBits = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data = 32'd0;
    logic        resp_valid;
    logic [31:0] ReadData;
    logic        resp_err;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_MemR = 1'b0;
    logic        z_MemWr = 1'b0;
    logic [31:0] z_addr = 32'd0;
    logic [31:0] z_data = 32'd0;
    logic        z_resp_valid;
    logic [31:0] z_ReadData;
    logic        z_resp_err;

    int total = 0;
    int bad = 0;
    logic [7:0] model_mem [NBYTES];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .MemR(MemR), .MemWr(MemWr), .MemRBits(MemRBits), .MemWrBits(MemWrBits),
        .addr(addr), .data(data), .resp_valid(resp_valid), .ReadData(ReadData),
        .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .MemR(z_MemR), .MemWr(z_MemWr), .MemRBits(3'd0), .MemWrBits(2'd0),
        .addr(z_addr), .data(z_data), .resp_valid(z_resp_valid), .ReadData(z_ReadData),
        .resp_err(z_resp_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int accessSize(input bit wr, input bit [2:0] rb, input bit [1:0] wb);
        if (wr) return (wb == 2'd1) ? 2 : ((wb == 2'd2) ? 1 : 4);
        return (rb == 3'd1 || rb == 3'd2) ? 2 : ((rb == 3'd3 || rb == 3'd4) ? 1 : 4);
    endfunction

    // Drives one access, waits for its response and reports what came back.
    task automatic applyStimulus(input bit wr, input bit both, input bit [2:0] rb, input bit [1:0] wb,
                                 input logic [31:0] a, input logic [31:0] d, input bit noise,
                                 output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        MemWr     = wr;
        MemR      = wr ? both : 1'b1;
        MemRBits  = rb;
        MemWrBits = wb;
        addr      = a;
        data      = d;
        checkOutput("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            checkOutput("ready_busy", {31'd0, req_ready}, 32'd0);
            if (noise) begin
                MemR      = 1'($urandom);
                MemWr     = 1'($urandom);
                MemRBits  = 3'($urandom);
                MemWrBits = 2'($urandom);
                addr      = $urandom;
                data      = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end while (!resp_valid && lat < 40);
        rd  = ReadData;
        err = resp_err;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("pulse_end", {31'd0, resp_valid}, 32'd0);
        checkOutput("rdata_idle", ReadData, 32'd0);
    endtask

    // Runs an access and compares latency, data and error flag with the byte-level model.
    task automatic doAccess(input bit wr, input bit both, input bit [2:0] rb, input bit [1:0] wb,
                            input logic [31:0] a, input logic [31:0] d, input bit noise,
                            output logic [31:0] rd);
        int size, b, lat;
        bit mis, exp_err;
        longint unsigned base, v, lim;
        logic err;
        size = accessSize(wr, rb, wb);
        mis  = (a % size) != 0;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        exp_err = mis;
        base    = a;
`else
        exp_err = 1'b0;
        base    = a - (a % size);
`endif
        b = int'(base % NBYTES);
        v = 0;
        if (!exp_err) begin
            if (wr) begin
                for (int i = 0; i < size; i++) model_mem[(b + i) % NBYTES] = 8'(d >> (8 * i));
            end else begin
                for (int i = 0; i < size; i++) v = v + (longint'(model_mem[(b + i) % NBYTES]) << (8 * i));
                lim = 64'd1 << (8 * size);
                if ((rb == 3'd1 || rb == 3'd3) && size < 4 && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
            end
        end
        applyStimulus(wr, both, rb, wb, a, d, noise, rd, err, lat);
        checkOutput("latency", lat, WAITC + 1);
        checkOutput("rdata", rd, 32'(v));
        checkOutput("err", {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] rd, old20;
        int pulses;
        logic lerr;
        int llat;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_rdata", ReadData, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        for (int w = 0; w < DEPTH; w++) doAccess(1'b1, 1'b0, 3'd0, 2'd0, 32'(w * 4), $urandom, 1'b0, rd);

        doAccess(1'b1, 1'b0, 3'd0, 2'd0, 32'h10, 32'h12345678, 1'b0, rd);
        doAccess(1'b0, 1'b0, 3'd0, 2'd0, 32'h10, 32'd0, 1'b0, rd);
        checkOutput("lw10_a", rd, 32'h12345678);
        doAccess(1'b1, 1'b0, 3'd0, 2'd2, 32'h11, 32'h000000AB, 1'b0, rd);
        doAccess(1'b0, 1'b0, 3'd3, 2'd0, 32'h11, 32'd0, 1'b0, rd);
        checkOutput("lb11", rd, 32'hFFFFFFAB);
        doAccess(1'b0, 1'b0, 3'd4, 2'd0, 32'h11, 32'd0, 1'b0, rd);
        checkOutput("lbu11", rd, 32'h000000AB);
        doAccess(1'b0, 1'b0, 3'd0, 2'd0, 32'h10, 32'd0, 1'b0, rd);
        checkOutput("lw10_b", rd, 32'h1234AB78);
        doAccess(1'b1, 1'b0, 3'd0, 2'd1, 32'h12, 32'h00008001, 1'b0, rd);
        doAccess(1'b0, 1'b0, 3'd1, 2'd0, 32'h12, 32'd0, 1'b0, rd);
        checkOutput("lh12", rd, 32'hFFFF8001);
        doAccess(1'b0, 1'b0, 3'd2, 2'd0, 32'h12, 32'd0, 1'b0, rd);
        checkOutput("lhu12", rd, 32'h00008001);
        doAccess(1'b0, 1'b0, 3'd0, 2'd0, 32'h10, 32'd0, 1'b0, rd);
        checkOutput("lw10_c", rd, 32'h8001AB78);
        doAccess(1'b0, 1'b0, 3'd0, 2'd0, 32'h10 + 32'(NBYTES) * 3, 32'd0, 1'b1, rd);
        checkOutput("lw_wrap", rd, 32'h8001AB78);

        doAccess(1'b1, 1'b1, 3'd0, 2'd3, 32'h20, 32'h0BADF00D, 1'b0, rd);
        doAccess(1'b0, 1'b0, 3'd0, 2'd0, 32'h22, 32'd0, 1'b0, rd);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        checkOutput("lw22", rd, 32'd0);
        doAccess(1'b1, 1'b0, 3'd0, 2'd0, 32'h21, 32'h55555555, 1'b0, rd);
        doAccess(1'b0, 1'b0, 3'd0, 2'd0, 32'h20, 32'd0, 1'b0, rd);
        checkOutput("sw21_nowrite", rd, 32'h0BADF00D);
`else
        checkOutput("lw22", rd, 32'h0BADF00D);
`endif

        old20 = 32'h0BADF00D;
        @(negedge clk);
        req_valid = 1'b1; MemR = 1'b0; MemWr = 1'b1; MemWrBits = 2'd0;
        addr = 32'h20; data = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("async_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("async_valid", {31'd0, resp_valid}, 32'd0);
        pulses = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        checkOutput("no_pulse", pulses, 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 32'h20, 32'd0, 1'b0, rd, lerr, llat);
        checkOutput("first_acc_lat", llat, WAITC + 1);
        checkOutput("lw20_old", rd, old20);

        @(negedge clk);
        req_valid = 1'b1; MemR = 1'b0; MemWr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("noop_ready", {31'd0, req_ready}, 32'd1);
            checkOutput("noop_valid", {31'd0, resp_valid}, 32'd0);
        end
        req_valid = 1'b0;

        for (int n = 0; n < 250; n++) begin
            bit wr;
            wr = 1'($urandom);
            doAccess(wr, 1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom,
                     1'($urandom), rd);
        end

        @(negedge clk);
        z_req_valid = 1'b1; z_MemWr = 1'b1; z_MemR = 1'b0;
        z_addr = 32'h8; z_data = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("z_sw_lat", {31'd0, z_resp_valid}, 32'd1);
        z_MemWr = 1'b0; z_MemR = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("z_b2b_valid", {31'd0, z_resp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput("z_b2b_rdata", z_ReadData, (i % 2 == 1) ? 32'hCAFEF00D : 32'd0);
        end
        z_req_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit storage words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states between accept and response (range 0..15).
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate that the pipeline MEM stage presents an access.
REQ-006 req_ready  output  1  SHALL indicate that the responder accepts an access this cycle.
REQ-007 MemR, MemWr  input  1 each  SHALL select read or write; both high SHALL be treated as write.
REQ-008 MemRBits  input  3  SHALL encode the load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 SHALL be treated as lw.
REQ-009 MemWrBits  input  2  SHALL encode the store type: 00 sw, 01 sh, 10 sb; 11 SHALL be treated as sw.
REQ-010 addr  input  32  SHALL be the byte address; data  input  32  SHALL be the store data, low-aligned.
REQ-011 resp_valid  output  1  SHALL be a one-cycle pulse marking completion of an accepted access.
REQ-012 ReadData  output  32  SHALL carry the extended load result, valid while resp_valid is high.
REQ-013 resp_err  output  1  SHALL flag a misaligned access, valid while resp_valid is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be high only in IDLE; an access is accepted on a cycle where req_valid, req_ready and (MemR or MemWr) are all high.
REQ-016 On accept, addr, data, both Bits fields and the direction SHALL be latched; while busy, input changes SHALL have no effect.
REQ-017 From IDLE, an accept SHALL go to WAIT when WAIT_CYCLES>0, otherwise directly to RESP.
REQ-018 WAIT SHALL count down from WAIT_CYCLES and go to RESP when the count reaches 1.
REQ-019 RESP SHALL hold for one cycle with resp_valid=1, then return to IDLE; accept-to-resp_valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-020 A store SHALL update memory at the RESP edge: sb writes byte addr[1:0], sh writes halfword addr[1], sw writes the full word; other bytes SHALL be preserved.
REQ-021 A load SHALL select byte or halfword by addr[1:0] (little-endian); lh and lb SHALL sign-extend; lhu and lbu SHALL zero-extend.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-023 For a store, ReadData SHALL be 0; outside RESP, ReadData and resp_err SHALL be 0.
REQ-024 req_valid with MemR=MemWr=0 SHALL not be accepted and SHALL not change state.

Reset
REQ-025 rst low SHALL immediately force IDLE, req_ready=1, resp_valid=0, ReadData=0, resp_err=0 and clear the wait counter.
REQ-026 Reset SHALL not clear storage contents; an access in flight at reset SHALL be discarded and its store SHALL not be performed.
REQ-027 The first accept after reset SHALL be possible on the first rising edge on which rst is high.

Configuration
REQ-028 With DMEM_RESP_ALIGN_CHECK_EN defined, an access whose alignment is violated (sw/lw with addr[1:0]!=0; sh/lh/lhu with addr[0]=1) SHALL set resp_err=1, suppress the memory write and return ReadData=0.
REQ-029 Without DMEM_RESP_ALIGN_CHECK_EN, resp_err SHALL be tied to 0 and the offending low address bits SHALL be forced to 0 before the access.

Verification
REQ-030 With WAIT_CYCLES=2: sw 0x12345678 to 0x10, then lw 0x10 -> resp_valid 3 cycles after each accept, ReadData=0x12345678.
REQ-031 After REQ-030: sb 0xAB to 0x11, then lb 0x11 -> ReadData=0xFFFFFFAB; lbu 0x11 -> 0x000000AB; lw 0x10 -> 0x1234AB78.
REQ-032 sh 0x8001 to 0x12, then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001; lw 0x10 -> 0x8001AB78.
REQ-033 Hold req_valid high with changing addr during WAIT -> req_ready=0 and only the first access completes; with WAIT_CYCLES=0, back-to-back accepts occur every 2 cycles.
REQ-034 Assert rst low one cycle after accepting sw 0xDEADBEEF to 0x20 -> resp_valid never pulses and a later lw 0x20 returns the old value.
REQ-035 With the macro defined: lw 0x22 -> resp_err=1, ReadData=0; sw to 0x21 leaves memory unchanged. With the macro undefined: lw 0x22 returns word 0x20 and resp_err=0.
